// File: rtl/wait_state_mem_pkg.sv
// Shared definitions for the wait-state memory slave.
//   MemState       : access sequencer states (IDLE, WAIT, DONE)
//   MEM_WORD_BYTES : bytes per storage word / byte-enable lanes
//   addr_fault     : misalignment / out-of-range decode for a byte address
package wait_state_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } MemState;

    localparam int MEM_WORD_BYTES = 4;

    // A byte address faults when it is not word aligned or when any bit
    // above the word-index field is set (idx_w = log2 of the word depth).
    function automatic logic addr_fault(input logic [31:0] a, input int idx_w);
        logic [31:0] hi;
        hi = a >> (idx_w + 2);
        return (a[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port-style RAM, DEPTH_WORDS x 32, with a byte-enable write port
// and a registered read port.
//   clk   : clock
//   we    : write strobe; bytes with be[i]=1 are written at widx
//   widx  : write word index
//   wdata : write data
//   be    : byte enables, be[i] -> wdata[8i+7:8i]
//   re    : read strobe; rdata is loaded from ridx on the next edge
//   ridx  : read word index
//   rdata : registered read data (holds between reads)
module mem_array
    import wait_state_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [IDX_W-1:0]          widx,
    input  logic [31:0]               wdata,
    input  logic [MEM_WORD_BYTES-1:0] be,
    input  logic                      re,
    input  logic [IDX_W-1:0]          ridx,
    output logic [31:0]               rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < MEM_WORD_BYTES; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[ridx];
        end
    end

endmodule

// File: rtl/wait_state_mem.sv
// Word-wide memory slave that inserts a fixed number of wait states per
// access and completes each access with a one-cycle ready pulse.
//   clk   : clock, all logic on the rising edge
//   res   : synchronous active-high reset (aborts any access in flight)
//   addr  : byte address; must be word aligned and inside the array
//   read  : read request, held until ready
//   write : write request, held until ready (wins over read)
//   wdata : write data
//   be    : byte enables for writes
//   rdata : read data, nonzero only during ready of a good read
//   ready : one-cycle completion pulse
//   err   : access fault, valid with ready
module wait_state_mem
    import wait_state_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] addr,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    MemState          state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             req, take;
    logic             flt_q, wr_q, ready_q;
    logic [IDX_W-1:0] idx_q, ridx;
    logic [31:0]      wdata_q, mem_q;
    logic [3:0]       be_q;
    logic             mem_we, mem_re;

    assign req  = read | write;
    assign take = (state == IDLE) && req;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_CYCLES == 0) ? DONE : WAIT;
                    cnt_nxt   = 4'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                // the edge that consumes the last wait state enters DONE
                if (cnt <= 4'd1) begin
                    state_nxt = DONE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ready_q <= 1'b0;
            flt_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ready_q <= (state_nxt == DONE);
            if (take) begin
                flt_q <= addr_fault(addr, IDX_W);
                wr_q  <= write;
            end
        end
    end

    // request capture: address, data and lanes are frozen for the access
    always_ff @(posedge clk) begin
        if (take) begin
            idx_q   <= addr[IDX_W+1:2];
            wdata_q <= wdata;
            be_q    <= be;
        end
    end

    // With zero wait states the read is launched on the sampling edge
    // itself, so the index must come straight from the bus in IDLE.
    assign ridx   = (state == IDLE) ? addr[IDX_W+1:2] : idx_q;
    assign mem_re = (state_nxt == DONE) && !res;
    assign mem_we = (state == DONE) && wr_q && !flt_q && !res;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .widx  (idx_q),
        .wdata (wdata_q),
        .be    (be_q),
        .re    (mem_re),
        .ridx  (ridx),
        .rdata (mem_q)
    );

    assign ready = ready_q;
    assign err   = ready_q & flt_q;
    assign rdata = (ready_q && !wr_q && !flt_q) ? mem_q : 32'd0;

endmodule

// File: tb/tb_wait_state_mem.sv
module tb_wait_state_mem;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: WAIT_CYCLES=2, instance B: WAIT_CYCLES=0
    logic        res_a, read_a, write_a, ready_a, err_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [3:0]  be_a;
    logic        res_b, read_b, write_b, ready_b, err_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [3:0]  be_b;

    wait_state_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .res(res_a), .addr(addr_a), .read(read_a), .write(write_a),
        .wdata(wdata_a), .be(be_a), .rdata(rdata_a), .ready(ready_a), .err(err_a)
    );

    wait_state_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .res(res_b), .addr(addr_b), .read(read_b), .write(write_b),
        .wdata(wdata_b), .be(be_b), .rdata(rdata_b), .ready(ready_b), .err(err_b)
    );

    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    exp_t qa[$];
    exp_t qb[$];
    int   last_r[2];
    logic [31:0] model [2][32];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cyc %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic mon(input bit s, input logic rdy, input logic er, input logic [31:0] rd);
        exp_t e;
        if (rdy) begin
            if ((s ? qb.size() : qa.size()) == 0) begin
                chk(s ? "unexpected_ready_b" : "unexpected_ready_a", 32'(rdy), 32'd0);
            end else begin
                e = s ? qb.pop_front() : qa.pop_front();
                chk(s ? "ready_cycle_b" : "ready_cycle_a", 32'(cyc), 32'(e.cyc));
                chk(s ? "err_b" : "err_a", 32'(er), 32'(e.err));
                chk(s ? "rdata_b" : "rdata_a", rd, e.rd);
            end
        end else begin
            chk(s ? "idle_outputs_b" : "idle_outputs_a", {rd[30:0], er}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(1'b0, ready_a, err_a, rdata_a);
            mon(1'b1, ready_b, err_b, rdata_b);
        end
    end

    function automatic bit is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
    endfunction

    // Issue one access on instance s (called at a negedge). With abort set,
    // reset is pulsed one cycle after the request is taken and nothing is
    // expected from the access.
    task automatic txn(input bit s, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b, input bit abort);
        int   smp, n, wc;
        exp_t e;
        logic [4:0] idx;
        bit   flt;
        wc  = s ? 0 : 2;
        smp = (cyc > last_r[s] + 1) ? cyc : last_r[s] + 1;
        if (s) begin
            addr_b = a; wdata_b = wd; be_b = b; read_b = rd; write_b = wr;
        end else begin
            addr_a = a; wdata_a = wd; be_a = b; read_a = rd; write_a = wr;
        end
        flt = is_fault(a);
        idx = a[6:2];
        if (abort) begin
            while (cyc < smp + 1) @(negedge clk);
            res_a = 1'b1; read_a = 1'b0; write_a = 1'b0;
            @(negedge clk);
            res_a = 1'b0;
            last_r[s] = -100;
            return;
        end
        e.cyc = smp + wc + 1;
        e.err = flt;
        e.rd  = (!wr && !flt) ? model[s][idx] : 32'd0;
        if (s) qb.push_back(e); else qa.push_back(e);
        if (wr && !flt) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) model[s][idx][8*i +: 8] = wd[8*i +: 8];
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (s ? ready_b : ready_a) break;
            n++;
            if (n > 40) begin
                chk("ready_timeout", 32'd0, 32'd1);
                break;
            end
            // bus contents after sampling must not matter
            if (cyc > smp) begin
                if (s) begin
                    addr_b = $urandom; wdata_b = $urandom; be_b = 4'($urandom);
                end else begin
                    addr_a = $urandom; wdata_a = $urandom; be_a = 4'($urandom);
                end
            end
        end
        last_r[s] = cyc;
        if (s) begin read_b = 1'b0; write_b = 1'b0; end
        else   begin read_a = 1'b0; write_a = 1'b0; end
    endtask

    function automatic logic [31:0] gen_addr();
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        a = 32'($urandom_range(0, 31)) << 2;
        if (r == 0) a = a | 32'($urandom_range(1, 3));
        else if (r == 1) a = a | (32'd1 << $urandom_range(12, 31));
        return a;
    endfunction

    initial begin
        bit rd, wr;
        last_r[0] = -100;
        last_r[1] = -100;
        res_a = 1'b1; read_a = 1'b0; write_a = 1'b0; addr_a = '0; wdata_a = '0; be_a = '0;
        res_b = 1'b1; read_b = 1'b0; write_b = 1'b0; addr_b = '0; wdata_b = '0; be_b = '0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        res_a = 1'b0; res_b = 1'b0;
        @(negedge clk);

        // write then read back at 0x40
        txn(0, 0, 1, 32'h40, 32'hDEADBEEF, 4'hF, 0);
        txn(0, 1, 0, 32'h40, 32'h0, 4'h0, 0);

        // initialise the whole test window with full-word writes
        for (int i = 0; i < 32; i++)
            txn(0, 0, 1, 32'(i) << 2, $urandom, 4'hF, 0);

        // partial byte write over a known word
        txn(0, 0, 1, 32'h48, 32'h11223344, 4'hF, 0);
        txn(0, 0, 1, 32'h48, 32'hAABBCCDD, 4'b0101, 0);
        txn(0, 1, 0, 32'h48, 32'h0, 4'h0, 0);
        txn(0, 0, 1, 32'h48, 32'hFFFFFFFF, 4'b0000, 0);
        txn(0, 1, 0, 32'h48, 32'h0, 4'h0, 0);

        // faults: misaligned read, out-of-range write aliasing word 0
        txn(0, 1, 0, 32'h41, 32'h0, 4'h0, 0);
        txn(0, 0, 1, 32'h1000, 32'hCAFEF00D, 4'hF, 0);
        txn(0, 1, 0, 32'h0, 32'h0, 4'h0, 0);
        txn(0, 1, 0, 32'h1000, 32'h0, 4'h0, 0);

        // read and write together behave as a write
        txn(0, 1, 1, 32'h4C, 32'd5, 4'hF, 0);
        txn(0, 1, 0, 32'h4C, 32'h0, 4'h0, 0);

        // reset during the wait states of a write
        txn(0, 0, 1, 32'h50, 32'h0BADC0DE, 4'hF, 0);
        txn(0, 0, 1, 32'h50, 32'h12345678, 4'hF, 1);
        txn(0, 1, 0, 32'h50, 32'h0, 4'h0, 0);

        // zero wait states: back-to-back write/read at 0x44
        for (int i = 0; i < 6; i++) begin
            txn(1, 0, 1, 32'h44, $urandom, 4'hF, 0);
            txn(1, 1, 0, 32'h44, 32'h0, 4'h0, 0);
        end

        // randomized traffic on both instances
        for (int i = 0; i < 32; i++)
            txn(1, 0, 1, 32'(i) << 2, $urandom, 4'hF, 0);
        for (int k = 0; k < 300; k++) begin
            bit s;
            s  = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            wr = (rd && $urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            txn(s, rd, wr, gen_addr(), $urandom, 4'($urandom), 0);
        end

        repeat (5) @(negedge clk);
        chk("pending_a", 32'(qa.size()), 32'd0);
        chk("pending_b", 32'(qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cyc %0d: got running, expected finished", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wait_state_mem.md
WAIT_STATE_MEM -- requirements
Module: wait_state_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words; power of two, 16..65536.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: extra wait states per access; 0..15.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on the posedge.
REQ-004 SHALL have port res, input, 1: reset; synchronous, active-high.
REQ-005 SHALL have port addr, input, 32: byte address; bits [1:0] give alignment.
REQ-006 SHALL have port read, input, 1: read request; held until ready.
REQ-007 SHALL have port write, input, 1: write request; held until ready.
REQ-008 SHALL have port wdata, input, 32: write data from the master.
REQ-009 SHALL have port be, input, 4: byte enables; be[i] selects wdata[8i+7:8i].
REQ-010 SHALL have port rdata, output, 32: read data; valid only while ready=1 for a read.
REQ-011 SHALL have port ready, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1: access fault; valid only while ready=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-014 IDLE: if (read|write)=1, SHALL latch addr, wdata, be and op, then go to WAIT (WAIT_CYCLES>0) or DONE (WAIT_CYCLES=0).
REQ-015 WAIT: SHALL count WAIT_CYCLES cycles with a 4-bit down-counter, then go to DONE.
REQ-016 DONE: SHALL assert ready for exactly one cycle, then return to IDLE.
REQ-017 Latency: ready SHALL rise WAIT_CYCLES+1 cycles after the request is sampled in IDLE.
REQ-018 Back-to-back: IDLE SHALL sample a new request the cycle after ready; minimum period is WAIT_CYCLES+2 cycles.
REQ-019 read=write=1 SHALL be treated as a write.
REQ-020 Request inputs changing while in WAIT or DONE SHALL be ignored; only latched values are used.
REQ-021 Word index SHALL be latched addr[log2(DEPTH_WORDS)+1:2].
REQ-022 Write SHALL update only the be-enabled bytes, committed on the DONE clock edge.
REQ-023 be=0000 on a write SHALL complete normally with memory unchanged.
REQ-024 Read: rdata SHALL hold the word at the latched index, registered on entry to DONE.
REQ-025 Fault: err=1 with ready when addr[1:0]!=0 or addr[31:log2(DEPTH_WORDS)+2]!=0.
REQ-026 On a fault, a write SHALL be dropped and read rdata SHALL be 0.
REQ-027 rdata SHALL be 0 whenever ready=0 or the access is a write.

Reset
REQ-028 res=1 SHALL force state IDLE, counter 0, ready=0, err=0, rdata=0 on the next edge.
REQ-029 Reset mid-access SHALL abort the access; no write is committed and no ready is issued.
REQ-030 Reset SHALL NOT clear memory contents; they are undefined unless preloaded by the bench.

Structure
REQ-031 Shared package SHALL hold the FSM state enum (MemState: IDLE, WAIT, DONE) and the constant MEM_WORD_BYTES=4.
REQ-032 Storage SHALL be one sub-module, mem_array: a byte-enable write-port RAM (DEPTH_WORDS x 32) with a registered read.
REQ-033 wait_state_mem SHALL contain only the FSM, the counter, fault decode and output registers.

Verification
REQ-034 WAIT_CYCLES=2; write 0xDEADBEEF to 0x40, be=1111 -> ready on the 3rd cycle after sampling, err=0; then read 0x40 -> rdata=0xDEADBEEF.
REQ-035 WAIT_CYCLES=0; alternate write/read at 0x44 every 2 cycles -> ready every 2nd cycle with correct rdata.
REQ-036 Preload 0x11223344 at 0x48; write 0xAABBCCDD with be=0101 -> read gives 0x11BB33DD.
REQ-037 Read 0x41, then write to 0x1000 with DEPTH_WORDS=1024 -> both give err=1 with ready; memory unchanged; read rdata=0.
REQ-038 read=write=1 at 0x4C with wdata=5 -> treated as a write; a later read returns 5.
REQ-039 Assert res in the WAIT state during a write to 0x50 -> no ready pulse; 0x50 keeps its old value; next request completes with normal latency.
